// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared constants for the gate truth-table checker.
// Holds the sweep FSM state encoding and expected truth tables for common 2-input gates.
// Truth tables are indexed by input vector: bit i is the expected output when vec == i.
package gate_chk_pkg;

  // Sweep FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Expected truth tables for 2-input gates (vec[1] = a, vec[0] = b)
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;

endpackage

// File: rtl/gate_truth_checker_settle_timer.sv
// settle_timer: loadable down-counter that times how long each vector is held.
// Ports: clk/rst_n; i_load + i_load_val reload the count; i_dec decrements;
// o_zero flags a count of zero. Load takes priority over decrement.
module settle_timer #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps every input combination onto a combinational gate,
// holds each for SETTLE cycles, samples y for one cycle and scores it against TRUTH.
// Ports: clk, rst_n, start, y (gate output) in; vec (gate inputs), busy, done, pass,
// err_count, fail_mask out. Results hold in DONE until the next accepted start.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int                N_IN   = 2,
  parameter int                SETTLE = 1,
  parameter logic [2**N_IN-1:0] TRUTH = TT_OR2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                y,
  output logic [N_IN-1:0]     vec,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_IN:0]       err_count,
  output logic [2**N_IN-1:0]  fail_mask
);

  // Counter only needs to hold SETTLE-1
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST  = {N_IN{1'b1}};

  logic [1:0]          r_state;
  logic [N_IN-1:0]     r_idx;
  logic [N_IN-1:0]     r_vec;
  logic                r_busy;
  logic                r_done;
  logic [N_IN:0]       r_err;
  logic [2**N_IN-1:0]  r_mask;

  logic w_accept;
  logic w_last;
  logic w_load;
  logic w_dec;
  logic w_zero;
  logic w_mismatch;

  // start is only honoured when no sweep is running
  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
  assign w_last   = (r_idx == IDX_LAST);
  assign w_load   = w_accept || ((r_state == ST_SAMPLE) && !w_last);
  assign w_dec    = (r_state == ST_APPLY) && !w_zero;

  // Case equality so an X/Z output from the gate scores as a failure
  assign w_mismatch = !(y === TRUTH[r_idx]);

  settle_timer #(
    .CW (CW)
  ) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (SETTLE_LD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_vec   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= '0;
      r_mask  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_APPLY;
            r_idx   <= '0;
            r_vec   <= '0;
            r_err   <= '0;
            r_mask  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (w_zero) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (w_mismatch) begin
            r_err         <= r_err + 1'b1;
            r_mask[r_idx] <= 1'b1;
          end
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_vec   <= '0;
          end else begin
            // Next vector goes out on the same edge the index advances
            r_idx   <= r_idx + 1'b1;
            r_vec   <= r_idx + 1'b1;
            r_state <= ST_APPLY;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign vec       = r_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_done && (r_err == '0);
  assign err_count = r_err;
  assign fail_mask = r_mask;

endmodule

// File: tb/tb_gate_truth_checker.sv
module tb_gate_truth_checker;
  import gate_chk_pkg::*;

  localparam int M_OR  = 0;
  localparam int M_S0  = 1;
  localparam int M_S1  = 2;
  localparam int M_AND = 3;

  typedef struct {
    logic [1:0] vec;
    logic       busy;
    logic       done;
  } cyc_t;

  typedef struct {
    int         err;
    logic [3:0] mask;
    logic       pass;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic y0, y1;
  logic [1:0] vec0, vec1;
  logic busy0, busy1, done0, done1, pass0, pass1;
  logic [2:0] err0, err1;
  logic [3:0] mask0, mask1;

  int gut0_mode = M_OR;
  int gut1_mode = M_AND;
  int sel = 0;

  int n_tests = 0;
  int n_fail  = 0;

  cyc_t cyc_q[$];
  res_t res_q[$];

  logic [1:0] m_vec;
  logic       m_busy, m_done, m_pass;
  logic [2:0] m_err;
  logic [3:0] m_mask;

  always #5 clk = ~clk;

  function automatic logic gut_y(input int mode, input logic [1:0] v);
    case (mode)
      M_OR:    return v[1] | v[0];
      M_AND:   return v[1] & v[0];
      M_S0:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  always_comb begin
    y0 = gut_y(gut0_mode, vec0);
    y1 = gut_y(gut1_mode, vec1);
  end

  always_comb begin
    m_vec  = vec0;  m_busy = busy0; m_done = done0;
    m_pass = pass0; m_err  = err0;  m_mask = mask0;
    if (sel == 1) begin
      m_vec  = vec1;  m_busy = busy1; m_done = done1;
      m_pass = pass1; m_err  = err1;  m_mask = mask1;
    end
  end

  gate_truth_checker #(.N_IN(2), .SETTLE(1), .TRUTH(TT_OR2)) dut_or (
    .clk(clk), .rst_n(rst_n), .start(start0), .y(y0), .vec(vec0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_mask(mask0)
  );

  gate_truth_checker #(.N_IN(2), .SETTLE(3), .TRUTH(TT_AND2)) dut_and (
    .clk(clk), .rst_n(rst_n), .start(start1), .y(y1), .vec(vec1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_mask(mask1)
  );

  task automatic set_start(input int s, input logic v);
    if (s == 1) start1 = v;
    else        start0 = v;
  endtask

  // One full sweep: expectations queued up front, compared cycle by cycle.
  task automatic run_sweep(input int s, input int mode, input int repulse, input string nm);
    int per, len, e_err;
    logic [3:0] tt, e_mask;
    logic [1:0] vv;
    cyc_t ec;
    res_t er;
    per = (s == 1) ? 4 : 2;
    len = 4 * per;
    tt  = (s == 1) ? TT_AND2 : TT_OR2;
    if (s == 1) gut1_mode = mode;
    else        gut0_mode = mode;
    sel = s;
    e_err = 0;
    e_mask = 4'b0;
    for (int v = 0; v < 4; v++) begin
      vv = 2'(v);
      if (gut_y(mode, vv) != tt[v]) begin
        e_mask[v] = 1'b1;
        e_err++;
      end
    end
    res_q.push_back('{err: e_err, mask: e_mask, pass: (e_err == 0)});
    for (int k = 0; k <= len; k++)
      cyc_q.push_back('{vec: (k < len) ? 2'(k / per) : 2'd0, busy: (k < len), done: (k == len)});
    set_start(s, 1'b1);
    for (int k = 0; k <= len; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) set_start(s, 1'b0);
      if (k == repulse) set_start(s, 1'b1);
      if (repulse >= 0 && k == repulse + 1) set_start(s, 1'b0);
      ec = cyc_q.pop_front();
      n_tests++;
      if (m_vec !== ec.vec) begin
        n_fail++;
        $display("FAIL %s vec k=%0d: got %0d expected %0d", nm, k, m_vec, ec.vec);
      end
      n_tests++;
      if (m_busy !== ec.busy) begin
        n_fail++;
        $display("FAIL %s busy k=%0d: got %0b expected %0b", nm, k, m_busy, ec.busy);
      end
      n_tests++;
      if (m_done !== ec.done) begin
        n_fail++;
        $display("FAIL %s done k=%0d: got %0b expected %0b", nm, k, m_done, ec.done);
      end
      if (k == 0) begin
        n_tests++;
        if (m_err !== 3'd0 || m_mask !== 4'b0) begin
          n_fail++;
          $display("FAIL %s clear_on_accept: got err=%0d mask=%b expected 0/0000", nm, m_err, m_mask);
        end
      end
      if (k == len) begin
        er = res_q.pop_front();
        n_tests++;
        if (m_err !== 3'(er.err)) begin
          n_fail++;
          $display("FAIL %s err_count: got %0d expected %0d", nm, m_err, er.err);
        end
        n_tests++;
        if (m_mask !== er.mask) begin
          n_fail++;
          $display("FAIL %s fail_mask: got %b expected %b", nm, m_mask, er.mask);
        end
        n_tests++;
        if (m_pass !== er.pass) begin
          n_fail++;
          $display("FAIL %s pass: got %0b expected %0b", nm, m_pass, er.pass);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_tests++;
    if ({vec0, busy0, done0, pass0, err0, mask0} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_or: got %b expected all zero", {vec0, busy0, done0, pass0, err0, mask0});
    end
    n_tests++;
    if ({vec1, busy1, done1, pass1, err1, mask1} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_and: got %b expected all zero", {vec1, busy1, done1, pass1, err1, mask1});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_clean_or();
    run_sweep(0, M_OR, -1, "clean_or");
  endtask

  task automatic test_stuck0();
    run_sweep(0, M_S0, -1, "stuck0");
  endtask

  task automatic test_and_settle3();
    run_sweep(1, M_AND, -1, "and_settle3");
  endtask

  task automatic test_start_while_busy();
    run_sweep(0, M_OR, 3, "start_busy");
  endtask

  task automatic test_reset_mid();
    sel = 0;
    gut0_mode = M_OR;
    start0 = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) start0 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({vec0, busy0, done0, pass0, err0, mask0} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b expected all zero", {vec0, busy0, done0, pass0, err0, mask0});
    end
    for (int k = 6; k <= 7; k++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_hold k=%0d: got done=%0b busy=%0b expected 0/0", k, done0, busy0);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (done0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got done=%0b busy=%0b expected 0/0", done0, busy0);
    end
    run_sweep(0, M_OR, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_sweep(0, M_S1, -1, "stuck1");
    run_sweep(0, M_OR, -1, "restart_or");
  endtask

  task automatic test_start_held();
    int first_done, second_done, ndone;
    logic busy9;
    sel = 0;
    gut0_mode = M_OR;
    first_done = -1;
    second_done = -1;
    ndone = 0;
    busy9 = 1'b0;
    start0 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done0 === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
      if (k == 9) busy9 = busy0;
    end
    start0 = 1'b0;
    n_tests++;
    if (first_done != 8 || second_done != 17 || ndone != 2) begin
      n_fail++;
      $display("FAIL start_held done_edges: got %0d,%0d (n=%0d) expected 8,17 (n=2)", first_done, second_done, ndone);
    end
    n_tests++;
    if (busy9 !== 1'b1) begin
      n_fail++;
      $display("FAIL start_held rerun_busy: got %0b expected 1", busy9);
    end
    // Drain the sweep launched at the last DONE cycle, bounded
    begin
      int wait_n;
      wait_n = 0;
      while (done0 !== 1'b1 && wait_n < 40) begin
        @(posedge clk);
        #1;
        wait_n++;
      end
      n_tests++;
      if (done0 !== 1'b1) begin
        n_fail++;
        $display("FAIL start_held drain: got done=%0b expected 1", done0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_or();
    test_stuck0();
    test_and_settle3();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_start_held();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
